transpose_feed_ctrl: RTL

Sequencer for a bank of DIM transpose FIFOs (each DIM entries deep) feeding the systolic array. It fetches DIM vectors from operand memory, parallel-loads vector k into FIFO k, then shifts all FIFOs out with a one-cycle diagonal skew per FIFO so the array receives correctly staggered operands. The block is control-only: the memory data bus is broadcast to every FIFO's parallel input, and only the per-FIFO write and shift strobes come from this block.

---
 rtl/transpose_pkg.sv | 19 +
 rtl/skew_window_decode.sv | 27 ++
 rtl/transpose_feed_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/transpose_pkg.sv
// Shared types and sizing helpers for the transpose FIFO feed sequencer.
package transpose_pkg;

  // Pass sequencing: fetch DIM vectors, drain with diagonal skew, pulse done.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DIM_DEFAULT = 8;

  // Drain counter must reach 2*DIM-2 (last FIFO's last shift).
  function automatic int cnt_width(input int dim);
    return $clog2(2 * dim);
  endfunction

endpackage

// File: rtl/skew_window_decode.sv
// Per-FIFO shift window: FIFO k shifts while cnt is in [k, k+DIM).
// The compare is done one bit wider than cnt because k+DIM can exceed
// the largest cnt value.
module skew_window_decode #(
  parameter int DIM  = 8,
  parameter int CNTW = 4
) (
  input  logic [CNTW-1:0] cnt_i,
  input  logic            en_i,
  output logic [DIM-1:0]  fifo_en_o
);

  localparam int WW = CNTW + 1;

  logic [WW-1:0] cnt_w;
  assign cnt_w = {1'b0, cnt_i};

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_win
      localparam logic [WW-1:0] LO = WW'(gi);
      localparam logic [WW-1:0] HI = WW'(gi + DIM);
      assign fifo_en_o[gi] = en_i && (cnt_w >= LO) && (cnt_w < HI);
    end
  endgenerate

endmodule

// File: rtl/transpose_feed_ctrl.sv
// Load/drain sequencer for a bank of DIM transpose FIFOs. Vector k is
// parallel-loaded into FIFO k, then all FIFOs shift out with one cycle of
// skew per FIFO. Only strobes are produced; data travels on the shared bus.
module transpose_feed_ctrl
  import transpose_pkg::*;
#(
  parameter int DIM  = DIM_DEFAULT,
  parameter int IDXW = $clog2(DIM),
  parameter int CNTW = cnt_width(DIM)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hold,
  output logic            rd_req,
  output logic [IDXW-1:0] rd_idx,
  input  logic            rd_valid,
  output logic [DIM-1:0]  fifo_wr,
  output logic [DIM-1:0]  fifo_en,
  output logic            busy,
  output logic            done
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIM - 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(2 * DIM - 2);
  localparam logic [DIM-1:0]  WR_ONE   = DIM'(1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] ld_idx_q, ld_idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            drain_en;

  // State and counter registers; reset also abandons any pass in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ld_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ld_idx_q <= ld_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: fetch advances on rd_valid, drain advances unless held.
  always_comb begin
    state_d  = state_q;
    ld_idx_d = ld_idx_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          ld_idx_d = '0;
        end
      end
      LOAD: begin
        if (rd_valid) begin
          if (ld_idx_q == LAST_IDX) begin
            state_d  = DRAIN;
            ld_idx_d = '0;
            cnt_d    = '0;
          end else begin
            ld_idx_d = ld_idx_q + IDXW'(1);
          end
        end
      end
      DRAIN: begin
        if (!hold) begin
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: status decoded from state; strobes gated by rd_valid / hold.
  always_comb begin
    rd_req   = (state_q == LOAD);
    rd_idx   = ld_idx_q;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    fifo_wr  = (state_q == LOAD && rd_valid) ? (WR_ONE << ld_idx_q) : '0;
    drain_en = (state_q == DRAIN) && !hold;
  end

  skew_window_decode #(
    .DIM  (DIM),
    .CNTW (CNTW)
  ) u_skew (
    .cnt_i     (cnt_q),
    .en_i      (drain_en),
    .fifo_en_o (fifo_en)
  );

endmodule
